// File: rtl/dual_req_sched.sv
// Request-collection stage: sticky pending register, top-two priority codes,
// per-consumer retire on acknowledge, and saturating served/dropped counters.
//
// state | meaning
// IDLE  | no request pending
// BUSY  | at least one request pending
module dual_req_sched #(
  parameter int N_REQ = 12,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req_in,
  input  logic             clr_all,
  input  logic             first_ack,
  input  logic             second_ack,
  output logic [N_REQ-1:0] pending,
  output logic [3:0]       first,
  output logic [3:0]       second,
  output logic             first_valid,
  output logic             second_valid,
  output logic             busy,
  output logic [CNT_W-1:0] served_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int PW = $clog2(N_REQ + 1);
  localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [N_REQ-1:0] pending_next;
  logic [N_REQ-1:0] clr_mask;
  logic [N_REQ-1:0] first_oh;
  logic [N_REQ-1:0] second_oh;
  logic [N_REQ-1:0] drop_bits;
  logic             take_first;
  logic             take_second;
  logic [1:0]       served_inc;
  logic [PW-1:0]    drop_inc;
  logic [CNT_W:0]   served_sum;
  logic [CNT_W:0]   drop_sum;
  logic [CNT_W-1:0] served_next;
  logic [CNT_W-1:0] drop_next;

  // Highest set bit wins: the loop runs upward so the last hit is the top bit.
  function automatic logic [3:0] top_code(input logic [N_REQ-1:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < N_REQ; i++)
      if (v[i]) c = 4'(i + 1);
    return c;
  endfunction

  function automatic logic [N_REQ-1:0] code_onehot(input logic [3:0] c);
    logic [N_REQ-1:0] m;
    m = '0;
    for (int i = 0; i < N_REQ; i++)
      if (c == 4'(i + 1)) m[i] = 1'b1;
    return m;
  endfunction

  always_comb begin
    first        = top_code(pending);
    first_oh     = code_onehot(first);
    second       = top_code(pending & ~first_oh);
    second_oh    = code_onehot(second);
    first_valid  = (first != 4'd0);
    second_valid = (second != 4'd0);
  end

  always_comb begin
    take_first  = first_ack & first_valid;
    take_second = second_ack & second_valid;
    clr_mask    = (take_first ? first_oh : '0) | (take_second ? second_oh : '0);

    if (clr_all) pending_next = '0;
    else         pending_next = (pending & ~clr_mask) | req_in;

    // A flush discards the acks, so they are not credited as served.
    served_inc = '0;
    if (!clr_all) served_inc = {1'b0, take_first} + {1'b0, take_second};

    drop_bits = req_in & pending & ~clr_mask;
    drop_inc  = '0;
    for (int i = 0; i < N_REQ; i++)
      drop_inc = drop_inc + PW'(drop_bits[i]);

    served_sum  = {1'b0, served_cnt} + (CNT_W + 1)'(served_inc);
    drop_sum    = {1'b0, drop_cnt} + (CNT_W + 1)'(drop_inc);
    served_next = (served_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : served_sum[CNT_W-1:0];
    drop_next   = (drop_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : drop_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pending    <= '0;
      busy       <= 1'b0;
      served_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      pending    <= pending_next;
      served_cnt <= served_next;
      drop_cnt   <= drop_next;
      case (state)
        IDLE: begin
          if (pending_next != '0) begin
            state <= BUSY;
            busy  <= 1'b1;
          end
        end
        BUSY: begin
          if (pending_next == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dual_req_sched.sv
// Scoreboard bench for dual_req_sched: the driver pushes model predictions,
// a monitor pops and compares one entry per clock after the edge.
module tb_dual_req_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] req_in;
  logic        clr_all;
  logic        first_ack;
  logic        second_ack;
  logic [11:0] pending;
  logic [3:0]  first;
  logic [3:0]  second;
  logic        first_valid;
  logic        second_valid;
  logic        busy;
  logic [7:0]  served_cnt;
  logic [7:0]  drop_cnt;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct packed {
    logic [11:0] pend;
    logic [3:0]  f;
    logic [3:0]  s;
    logic        fv;
    logic        sv;
    logic        bsy;
    logic [7:0]  srv;
    logic [7:0]  drp;
  } obs_t;

  obs_t exp_q[$];

  logic [11:0] m_pend = '0;
  int          m_srv  = 0;
  int          m_drp  = 0;

  dual_req_sched #(.N_REQ(12), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req_in(req_in), .clr_all(clr_all),
    .first_ack(first_ack), .second_ack(second_ack), .pending(pending),
    .first(first), .second(second), .first_valid(first_valid),
    .second_valid(second_valid), .busy(busy), .served_cnt(served_cnt),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] hi_code(input logic [11:0] v);
    for (int i = 11; i >= 0; i--)
      if (v[i]) return 4'(i + 1);
    return 4'd0;
  endfunction

  function automatic obs_t model_view();
    obs_t o;
    logic [11:0] rest;
    o.pend = m_pend;
    o.f    = hi_code(m_pend);
    rest   = m_pend;
    if (o.f != 0) rest[o.f - 1] = 1'b0;
    o.s    = hi_code(rest);
    o.fv   = (o.f != 0);
    o.sv   = (o.s != 0);
    o.bsy  = (m_pend != 0);
    o.srv  = 8'(m_srv);
    o.drp  = 8'(m_drp);
    return o;
  endfunction

  task automatic step(input logic r, input logic [11:0] rq, input logic ca,
                      input logic fa, input logic sa);
    obs_t now;
    logic [11:0] cm;
    int nd;
    @(negedge clk);
    reset = r; req_in = rq; clr_all = ca; first_ack = fa; second_ack = sa;
    now = model_view();
    if (r) begin
      m_pend = '0; m_srv = 0; m_drp = 0;
    end else begin
      cm = '0;
      if (fa && now.fv) cm[now.f - 1] = 1'b1;
      if (sa && now.sv) cm[now.s - 1] = 1'b1;
      nd = 0;
      for (int i = 0; i < 12; i++)
        if (rq[i] && m_pend[i] && !cm[i]) nd++;
      m_drp = (m_drp + nd > 255) ? 255 : m_drp + nd;
      if (!ca) begin
        m_srv  = m_srv + int'(fa && now.fv) + int'(sa && now.sv);
        if (m_srv > 255) m_srv = 255;
        m_pend = (m_pend & ~cm) | rq;
      end else begin
        m_pend = '0;
      end
    end
    exp_q.push_back(model_view());
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
  endtask

  // Direct checks against hand-computed constants, sampled after the next edge.
  task automatic hand(input string nm, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
  endtask

  task automatic settle();
    @(posedge clk); #2;
  endtask

  always @(posedge clk) begin
    obs_t e, a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{pending, first, second, first_valid, second_valid, busy, served_cnt, drop_cnt};
      n_total++;
      if (a === e) n_pass++;
      else $display("FAIL scoreboard @%0t: got pend=%h f=%0d s=%0d fv=%b sv=%b busy=%b srv=%0d drp=%0d, expected pend=%h f=%0d s=%0d fv=%b sv=%b busy=%b srv=%0d drp=%0d",
                    $time, a.pend, a.f, a.s, a.fv, a.sv, a.bsy, a.srv, a.drp,
                    e.pend, e.f, e.s, e.fv, e.sv, e.bsy, e.srv, e.drp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; req_in = 12'h801; clr_all = 1'b0; first_ack = 1'b0; second_ack = 1'b0;
    step(1'b1, 12'h801, 1'b0, 1'b0, 1'b0);
    step(1'b1, 12'h801, 1'b0, 1'b0, 1'b0);
    idle(3);
    settle();
    hand("reset_pending", int'(pending), 0);
    hand("reset_busy", int'(busy), 0);

    step(1'b0, 12'h821, 1'b0, 1'b0, 1'b0);
    settle();
    hand("pulse_pending", int'(pending), 'h821);
    hand("pulse_first", int'(first), 12);
    hand("pulse_second", int'(second), 6);
    step(1'b0, 12'h000, 1'b0, 1'b1, 1'b0);
    settle();
    hand("ack1_pending", int'(pending), 'h021);
    hand("ack1_first", int'(first), 6);
    hand("ack1_second", int'(second), 1);
    step(1'b0, 12'h000, 1'b0, 1'b1, 1'b1);
    settle();
    hand("ack2_pending", int'(pending), 0);
    hand("ack2_served", int'(served_cnt), 3);

    step(1'b0, 12'h004, 1'b0, 1'b0, 1'b0);
    step(1'b0, 12'h004, 1'b0, 1'b0, 1'b0);
    settle();
    hand("collide_drop", int'(drop_cnt), 1);
    step(1'b0, 12'h004, 1'b0, 1'b1, 1'b0);
    settle();
    hand("setwins_pending", int'(pending), 'h004);
    hand("setwins_served", int'(served_cnt), 4);
    hand("setwins_drop", int'(drop_cnt), 1);
    step(1'b0, 12'h000, 1'b0, 1'b1, 1'b0);

    step(1'b0, 12'h010, 1'b0, 1'b0, 1'b0);
    settle();
    hand("single_first", int'(first), 5);
    hand("single_sv", int'(second_valid), 0);
    step(1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
    settle();
    hand("sack_ignored_served", int'(served_cnt), 5);
    hand("sack_ignored_pending", int'(pending), 'h010);

    step(1'b0, 12'hFFF, 1'b0, 1'b0, 1'b0);
    step(1'b0, 12'h001, 1'b1, 1'b1, 1'b0);
    settle();
    hand("flush_pending", int'(pending), 0);
    hand("flush_busy", int'(busy), 0);
    hand("flush_served", int'(served_cnt), 5);

    for (int k = 0; k < 258; k++) step(1'b0, 12'h001, 1'b0, 1'b0, 1'b0);
    settle();
    hand("drop_sat", int'(drop_cnt), 255);
    for (int k = 0; k < 255; k++) step(1'b0, 12'h001, 1'b0, 1'b1, 1'b0);
    settle();
    hand("served_sat", int'(served_cnt), 255);

    step(1'b0, 12'hC30, 1'b0, 1'b1, 1'b1);
    step(1'b1, 12'hFFF, 1'b0, 1'b1, 1'b1);
    settle();
    hand("midreset_pending", int'(pending), 0);
    hand("midreset_served", int'(served_cnt), 0);
    hand("midreset_drop", int'(drop_cnt), 0);
    idle(2);

    repeat (2) @(posedge clk);
    #3;
    hand("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
